alu_multicycle: RTL
===================

// Module: alu_multicycle
// PURPOSE
// - Registered, parametrised-width ALU for the next CPU core: same op encoding and flags as the
//   combinational ALU, plus variable shifts and an iterative signed/unsigned divider.
// - Single-cycle ops complete in 1 clock; divide ops take WIDTH+2 clocks.
// - Sits between the register file and the writeback mux; the control FSM stalls on busy.
// PARAMETERS
// - WIDTH   32  datapath width; even, >= 8
// - SHW     $clog2(WIDTH)  shift-amount width, derived; do not override
// PORTS
// - clk          in   1      system clock, all state on rising edge
// - reset        in   1      asynchronous, active-high reset
// - start        in   1      launch op; sampled only when busy=0
// - op           in   8      operation code, see BEHAVIOUR
// - a, b         in   WIDTH  operands, captured on the accepted start
// - carry_in     in   1      carry/borrow in for ops 1 and 3
// - busy         out  1      1 from the cycle after an accepted divide start until done
// - done         out  1      1-cycle pulse: c and flags valid, then held until the next done
// - c            out  WIDTH  result
// - carry_out    out  1      bit WIDTH of the internal WIDTH+1 result
// - is_zero      out  1      c == 0
// - is_negative  out  1      c[WIDTH-1]
// - div_by_zero  out  1      set with done for a divide op with b == 0, else 0
// BEHAVIOUR
// - Reset: every output 0; FSM to IDLE; an in-flight divide is abandoned with no done.
// - Ops, as in the combinational ALU, with width WIDTH+1 and carry = MSB:
//   0 add, 1 adc, 2 sub, 3 sbc, 4 or, 5 and, 6 not a, 7 xor.
//   8 cmp: all-ones if a<b unsigned, 0 if equal, else 1.
//   9 pass a. 12 shl1 with carry=a[W-1]. 13 shr1 with carry=a[0].
//   16 a[W/2-1:0]*b[W/2-1:0]. 17 low W bits of a*b. 18 high W bits of unsigned a*b.
// - New ops:
//   14 shl a by b[SHW-1:0]. 15 logical shr. 19 arithmetic shr. Carry = last bit shifted out; 0 if amount=0.
//   20 divu quotient. 21 remu. 22 divs quotient, truncating. 23 rems, sign follows a.
//   All other codes give 0 with carry 0 and complete in 1 cycle.
// - FSM IDLE/DIV/FIX:
//   - IDLE, start, op not 20..23: result registered and done=1 on the next edge (latency 1);
//     back-to-back starts give done every cycle.
//   - IDLE, start, op 20..23: capture |a|,|b| and signs, go to DIV, busy=1.
//   - DIV: one restoring step per cycle, counter WIDTH-1 down to 0; at 0 go to FIX.
//   - FIX: apply sign correction, register c and flags, done=1, busy=0, go to IDLE.
//   - Divide latency: done WIDTH+2 cycles after the start edge.
// - start while busy=1 is ignored, and its operands are not captured.
// - Divide by zero: quotient all-ones, remainder = a, div_by_zero=1; full latency is kept.
// - divs MIN/-1: quotient = MIN, remainder 0, carry 0.
// - For divide ops carry_out is 0.
// - Flags are always derived from the registered c.
// STRUCTURE
// - Package alu_pkg: localparam op codes (OP_ADD..OP_REMS), FSM state enum, and the
//   is_multicycle(op) function.
// - Sub-module div_iter: serial restoring divider with start/busy/done, WIDTH-parametrised,
//   unsigned core only.
// - Sign handling and the op mux stay in alu_multicycle.
// TESTING
// - Reset held, then released, start op0 a=FFFFFFFF b=1 -> next cycle done=1, c=0,
//   carry_out=1, is_zero=1.
// - op20 a=100 b=7 -> busy for 33 cycles, done at cycle 34, c=14.
//   Then op21 -> c=2, div_by_zero=0.
// - op22 a=-7 b=2 -> c=-3 (FFFFFFFD), is_negative=1. op23 -> c=-1.
//   op22 a=80000000 b=FFFFFFFF -> c=80000000.
// - op20 a=5 b=0 -> c=FFFFFFFF, div_by_zero=1. op21 -> c=5.
// - Shifts: op14 a=1 b=31 -> c=80000000, carry 0. op19 a=80000000 b=4 -> c=F8000000.
//   op15 b=0 -> c=a, carry 0.
// - Start op20, assert start op0 mid-divide (ignored), then reset at cycle 10 -> no done,
//   all outputs 0.
//   After release, op18 a=b=FFFFFFFF -> c=FFFFFFFE. Repeat the bench with WIDTH=16.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM states and op classification shared by the multicycle ALU.
package alu_pkg;

    localparam logic [7:0] OP_ADD   = 8'd0;
    localparam logic [7:0] OP_ADC   = 8'd1;
    localparam logic [7:0] OP_SUB   = 8'd2;
    localparam logic [7:0] OP_SBC   = 8'd3;
    localparam logic [7:0] OP_OR    = 8'd4;
    localparam logic [7:0] OP_AND   = 8'd5;
    localparam logic [7:0] OP_NOT   = 8'd6;
    localparam logic [7:0] OP_XOR   = 8'd7;
    localparam logic [7:0] OP_CMP   = 8'd8;
    localparam logic [7:0] OP_PASS  = 8'd9;
    localparam logic [7:0] OP_SHL1  = 8'd12;
    localparam logic [7:0] OP_SHR1  = 8'd13;
    localparam logic [7:0] OP_SHL   = 8'd14;
    localparam logic [7:0] OP_SHR   = 8'd15;
    localparam logic [7:0] OP_MULH  = 8'd16;
    localparam logic [7:0] OP_MULL  = 8'd17;
    localparam logic [7:0] OP_MULHU = 8'd18;
    localparam logic [7:0] OP_SAR   = 8'd19;
    localparam logic [7:0] OP_DIVU  = 8'd20;
    localparam logic [7:0] OP_REMU  = 8'd21;
    localparam logic [7:0] OP_DIVS  = 8'd22;
    localparam logic [7:0] OP_REMS  = 8'd23;

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX} state_t;

    function automatic logic is_multicycle(input logic [7:0] op);
        return op >= OP_DIVU && op <= OP_REMS;
    endfunction

endpackage

// File: rtl/alu_multicycle_div.sv
// div_iter: serial unsigned restoring divider, one quotient bit per clock.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic [WIDTH:0]   sh_d, diff_d;
    logic             ge_d;

    assign sh_d   = {rem_q, quo_q[WIDTH-1]};
    assign diff_d = sh_d - {1'b0, dvs_q};
    assign ge_d   = sh_d >= {1'b0, dvs_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (!busy_q) begin
            if (start_i) begin
                rem_q  <= '0;
                quo_q  <= dividend_i;
                dvs_q  <= divisor_i;
                cnt_q  <= CW'(WIDTH - 1);
                busy_q <= 1'b1;
            end
        end else begin
            rem_q  <= ge_d ? diff_d[WIDTH-1:0] : sh_d[WIDTH-1:0];
            quo_q  <= {quo_q[WIDTH-2:0], ge_d};
            cnt_q  <= cnt_q - 1'b1;
            busy_q <= cnt_q != '0;
        end
    end

    // done marks the cycle whose closing edge writes the final quotient bit
    assign busy_o      = busy_q;
    assign done_o      = busy_q && cnt_q == '0;
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU with variable shifts and an iterative signed/unsigned divider.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] c,
    output logic             carry_out,
    output logic             is_zero,
    output logic             is_negative,
    output logic             div_by_zero
);
    localparam int H = WIDTH / 2;

    state_t           state_q;
    logic             busy_q, done_q, carry_q, zero_q, neg_q, dbz_q;
    logic [WIDTH-1:0] c_q, a_q;
    logic             sa_q, sb_q, rem_sel_q, bz_q;

    logic [WIDTH:0]     res_d, sh_d, sar_d;
    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH-1:0]   half_d, abs_a_d, abs_b_d, fix_d, dq, dr;
    logic [SHW-1:0]     amt_d;
    logic               sgn_d, sa_d, sb_d, div_start_d, div_busy, div_done;

    assign amt_d  = b[SHW-1:0];
    assign sh_d   = {a, 1'b0} >> amt_d;
    assign sar_d  = $signed({a, 1'b0}) >>> amt_d;
    assign prod_d = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign half_d = {{H{1'b0}}, a[H-1:0]} * {{H{1'b0}}, b[H-1:0]};

    always_comb begin
        res_d = '0;
        case (op)
            OP_ADD:   res_d = {1'b0, a} + {1'b0, b};
            OP_ADC:   res_d = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
            OP_SUB:   res_d = {1'b0, a} - {1'b0, b};
            OP_SBC:   res_d = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, carry_in};
            OP_OR:    res_d = {1'b0, a | b};
            OP_AND:   res_d = {1'b0, a & b};
            OP_NOT:   res_d = {1'b0, ~a};
            OP_XOR:   res_d = {1'b0, a ^ b};
            OP_CMP:   res_d = (a < b) ? {1'b0, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, a != b};
            OP_PASS:  res_d = {1'b0, a};
            OP_SHL1:  res_d = {a, 1'b0};
            OP_SHR1:  res_d = {a[0], 1'b0, a[WIDTH-1:1]};
            OP_SHL:   res_d = {1'b0, a} << amt_d;
            OP_SHR:   res_d = {sh_d[0], sh_d[WIDTH:1]};
            OP_SAR:   res_d = {sar_d[0], sar_d[WIDTH:1]};
            OP_MULH:  res_d = {1'b0, half_d};
            OP_MULL:  res_d = {1'b0, prod_d[WIDTH-1:0]};
            OP_MULHU: res_d = {1'b0, prod_d[2*WIDTH-1:WIDTH]};
            default:  res_d = '0;
        endcase
    end

    // The divider core is unsigned; signed ops divide magnitudes and fix signs afterwards
    assign sgn_d       = op == OP_DIVS || op == OP_REMS;
    assign sa_d        = sgn_d && a[WIDTH-1];
    assign sb_d        = sgn_d && b[WIDTH-1];
    assign abs_a_d     = sa_d ? -a : a;
    assign abs_b_d     = sb_d ? -b : b;
    assign div_start_d = state_q == S_IDLE && start && is_multicycle(op) && !div_busy;

    div_iter #(.WIDTH(WIDTH)) u_div (
        .clk         (clk),
        .reset       (reset),
        .start_i     (div_start_d),
        .dividend_i  (abs_a_d),
        .divisor_i   (abs_b_d),
        .busy_o      (div_busy),
        .done_o      (div_done),
        .quotient_o  (dq),
        .remainder_o (dr)
    );

    assign fix_d = bz_q      ? (rem_sel_q ? a_q : {WIDTH{1'b1}}) :
                   rem_sel_q ? (sa_q ? -dr : dr) :
                               ((sa_q ^ sb_q) ? -dq : dq);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            c_q       <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            neg_q     <= 1'b0;
            dbz_q     <= 1'b0;
            a_q       <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            rem_sel_q <= 1'b0;
            bz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && is_multicycle(op)) begin
                        a_q       <= a;
                        sa_q      <= sa_d;
                        sb_q      <= sb_d;
                        rem_sel_q <= op == OP_REMU || op == OP_REMS;
                        bz_q      <= b == '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_DIV;
                    end else if (start) begin
                        c_q     <= res_d[WIDTH-1:0];
                        carry_q <= res_d[WIDTH];
                        zero_q  <= res_d[WIDTH-1:0] == '0;
                        neg_q   <= res_d[WIDTH-1];
                        dbz_q   <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DIV: state_q <= div_done ? S_FIX : S_DIV;
                S_FIX: begin
                    c_q     <= fix_d;
                    carry_q <= 1'b0;
                    zero_q  <= fix_d == '0;
                    neg_q   <= fix_d[WIDTH-1];
                    dbz_q   <= bz_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign c           = c_q;
    assign carry_out   = carry_q;
    assign is_zero     = zero_q;
    assign is_negative = neg_q;
    assign div_by_zero = dbz_q;

endmodule
